clock_renderer: RTL and testbench
=================================

# clock_renderer

Per-pixel renderer for an analog 12-hour clock face on a 640x480 VGA raster. Takes the current beam position plus time and alarm values. Produces a 1-bit pixel (1 = white) for:
- the dial ring, 12 tick marks and centre hub;
- hour, minute, second and alarm hands.

Sits between the timekeeping logic and the VGA output stage. The caller ANDs the output with its own visible-area signal.

## Interface
Parameters:
- `CENTER_OFS`, default 220: dial centre relative to (`x_offset`, `y_offset`).
- `RING_R`, default 215: outer ring radius in pixels.
- `RING_W`, default 4: ring thickness in pixels.

Ports:
- `clk` input 1: pixel clock, 31.5 MHz.
- `reset` input 1: reset, synchronous, active-high; clock `clk`.
- `slow_clk` input 1: slow level signal (~50 Hz), synchronous to `clk`. Its rising edge samples the time inputs.
- `hour` input 4: hours, 0..11.
- `minute` input 6: minutes, 0..59.
- `second` input 6: seconds, 0..59.
- `al_hour` input 4: alarm hours, 0..11.
- `al_minute` input 6: alarm minutes, 0..59.
- `horizCounter` input 10: beam x.
- `vertCounter` input 10: beam y.
- `x_offset` input 10: dial bounding-box left edge.
- `y_offset` input 10: dial bounding-box top edge.
- `pixel_bw` output 1: pixel is white.

## Operation
**Time sampling**
- A one-register edge detector on `slow_clk` finds rising edges.
- On a detected edge, latch the five time inputs into shadow registers. Hands use only the shadow values, so there is no tearing mid-frame.
- Sanitise on latch: `minute`, `second` or `al_minute` ≥ 60 becomes 0; `hour` or `al_hour` ≥ 12 becomes 0.

**Angle indices** (0..59, 6° steps, 0 = 12 o'clock, clockwise)
- Second hand: `second`.
- Minute hand: `minute`.
- Hour hand: `hour*5 + minute/12`.
- Alarm hand: `al_hour*5 + al_minute/12`.

**Geometry**
- Centre: cx = `x_offset`+`CENTER_OFS`, cy = `y_offset`+`CENTER_OFS`.
- dx = x−cx and dy = y−cy, each signed 11-bit.
- Unit vector for index k: (S(k), −C(k)) in Q1.8, screen y down.
- S comes from the shared quarter-wave table over k=0..15: 0, 27, 53, 79, 104, 128, 150, 171, 190, 207, 222, 234, 243, 250, 255, 256. Quadrant symmetry gives the rest. C(k) = S(k+15 mod 60).
- Projection p = dx·S − dy·C. Perpendicular q = dx·C + dy·S. Both signed, at least 22 bits.

**Hand lit when** 0 ≤ p ≤ L·256 and |q| ≤ W·256:

| Hand | L | W |
|---|---|---|
| Second | 200 | 1 |
| Minute | 180 | 3 |
| Hour | 120 | 5 |
| Alarm | 90 | 1 |

The alarm hand is always drawn.

**Other features**
- Ring: (RING_R−RING_W)² ≤ dx²+dy² ≤ RING_R².
- Hub: dx²+dy² ≤ 64.
- Ticks: 7x7 squares, |dx−Tx| ≤ 3 and |dy−Ty| ≤ 3. (Tx, Ty) = round(195·S, −195·C) for k = 0, 5, …, 55, taken from a constant table.
- `pixel_bw` = OR of ring, hub, ticks and four hands.

## Timing
- `pixel_bw` latency is 2 `clk` cycles from `horizCounter`/`vertCounter`.
  - Stage 1 registers dx, dy and the angle lookups.
  - Stage 2 registers the products and compares, then drives the output register.
- The pipeline is fully streaming: one pixel per cycle, no stalls.
- Shadow-register update: the `clk` after the rising edge of `slow_clk` is detected. Time-input changes without a `slow_clk` edge have no visible effect.
- Reset:
  - `pixel_bw`=0.
  - All pipeline registers = 0.
  - Shadow time registers = 0.
  - Edge-detector register = 0.
  - `pixel_bw` is held 0 while `reset` is high.
- Reset asserted mid-line: output is 0 from the next cycle. Valid pixels resume 2 cycles after release.
- Beam outside the dial: features evaluate false naturally. Offsets wrap modulo 2^10 in unsigned math, but dx/dy use signed math.

## Structure
- Shared package `clock_render_pkg` holds:
  - the 16-entry quarter-sine table;
  - the 12-entry tick coordinate table;
  - the hand length/width constants;
  - Q1.8 width constants.
- Sub-module `hand_hit`: inputs dx, dy, angle index, L, W; output hit.
  - Instantiated four times: second, minute, hour, alarm.
- Ring, hub and tick logic stay in the top module.

## Test plan
- Assert `reset`, then sweep the frame → `pixel_bw`=0 throughout reset. Shadow regs = 0 after reset.
- Offsets (25,15), time 0:00:00, one `slow_clk` edge → pixel (245,235) = 1 (hub). Pixel (245,85) = 1 (hands up). Pixel (295,285) = 0.
- Latch 3:00:00 → (345,235) = 1 (hour). (245,75) = 1 (minute). (245,400) = 0.
- Pixel (458,235) = 1 (ring). (463,235) = 0. (245,40) = 1 (12 o'clock tick).
- Change `minute` to 30 with `slow_clk` held low → no change at (245,385). After a rising edge → (245,385) = 1.
- Drive `minute`=60 at latch → minute hand drawn at index 0.
- Step `horizCounter` by one → output changes exactly 2 cycles later.

Source files
------------

// File: rtl/clock_render_pkg.sv
// Shared constants and trig helpers for the analog clock-face renderer.
`default_nettype none

package clock_render_pkg;

  localparam int Q_W = 10;  // signed Q1.8 coefficient, covers -256..256
  localparam int D_W = 11;  // signed beam-to-centre distance
  localparam int P_W = 24;  // projection / perpendicular accumulator

  typedef logic signed [Q_W-1:0] coef_t;
  typedef logic signed [D_W-1:0] dist_t;

  localparam logic [8:0] QSIN [16] = '{
    9'd0,   9'd27,  9'd53,  9'd79,  9'd104, 9'd128, 9'd150, 9'd171,
    9'd190, 9'd207, 9'd222, 9'd234, 9'd243, 9'd250, 9'd255, 9'd256
  };

  localparam logic [7:0] SEC_L = 8'd200;
  localparam logic [2:0] SEC_W = 3'd1;
  localparam logic [7:0] MIN_L = 8'd180;
  localparam logic [2:0] MIN_W = 3'd3;
  localparam logic [7:0] HR_L  = 8'd120;
  localparam logic [2:0] HR_W  = 3'd5;
  localparam logic [7:0] AL_L  = 8'd90;
  localparam logic [2:0] AL_W  = 3'd1;

  localparam dist_t TICK_X [12] = '{
    11'sd0,    11'sd98,   11'sd169,  11'sd195,  11'sd169,  11'sd98,
    11'sd0,   -11'sd98,  -11'sd169, -11'sd195, -11'sd169, -11'sd98
  };
  localparam dist_t TICK_Y [12] = '{
   -11'sd195, -11'sd169, -11'sd98,   11'sd0,    11'sd98,   11'sd169,
    11'sd195,  11'sd169,  11'sd98,   11'sd0,   -11'sd98,  -11'sd169
  };

  function automatic coef_t sin_q8(input logic [5:0] k);
    logic [5:0] t;
    coef_t      v;
    if (k <= 6'd15) begin
      t = k;
      v = coef_t'({1'b0, QSIN[t[3:0]]});
    end else if (k <= 6'd30) begin
      t = 6'd30 - k;
      v = coef_t'({1'b0, QSIN[t[3:0]]});
    end else if (k <= 6'd45) begin
      t = k - 6'd30;
      v = -coef_t'({1'b0, QSIN[t[3:0]]});
    end else begin
      t = 6'd60 - k;
      v = -coef_t'({1'b0, QSIN[t[3:0]]});
    end
    return v;
  endfunction

  function automatic coef_t cos_q8(input logic [5:0] k);
    logic [5:0] j;
    j = (k >= 6'd45) ? (k - 6'd45) : (k + 6'd15);
    return sin_q8(j);
  endfunction

  // Hour-style index: coarse position plus one step per 12 minutes.
  function automatic logic [5:0] hand_idx(input logic [3:0] h, input logic [5:0] m);
    logic [6:0] t;
    t = {3'b000, h} * 7'd5 + {1'b0, m} / 7'd12;
    return t[5:0];
  endfunction

  function automatic logic near3(input dist_t a, input dist_t b);
    logic signed [11:0] d;
    d = 12'(a) - 12'(b);
    return (d >= -12'sd3) && (d <= 12'sd3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hand_hit.sv
// Tests whether a pixel offset lies on a clock hand of given angle, length and half-width.
`default_nettype none

module hand_hit
  import clock_render_pkg::*;
(
  input  logic signed [D_W-1:0] i_dx,
  input  logic signed [D_W-1:0] i_dy,
  input  logic [5:0]            i_idx,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_wid,
  output logic                  o_hit
);

  coef_t                  w_s, w_c;
  logic signed [P_W-1:0]  w_dx, w_dy, w_se, w_ce;
  logic signed [P_W-1:0]  w_p, w_q, w_lmax, w_wmax;

  assign w_s    = sin_q8(i_idx);
  assign w_c    = cos_q8(i_idx);
  assign w_dx   = P_W'(i_dx);
  assign w_dy   = P_W'(i_dy);
  assign w_se   = P_W'(w_s);
  assign w_ce   = P_W'(w_c);

  // Screen y grows downward, so the hand direction is (S, -C).
  assign w_p    = w_dx * w_se - w_dy * w_ce;
  assign w_q    = w_dx * w_ce + w_dy * w_se;
  assign w_lmax = signed'({8'b0, i_len, 8'b0});
  assign w_wmax = signed'({13'b0, i_wid, 8'b0});

  assign o_hit  = !w_p[P_W-1] && (w_p <= w_lmax) && (w_q <= w_wmax) && (w_q >= -w_wmax);

endmodule

`default_nettype wire

// File: rtl/clock_renderer.sv
// Two-stage per-pixel renderer for an analog clock face: ring, ticks, hub and four hands.
`default_nettype none

module clock_renderer
  import clock_render_pkg::*;
#(
  parameter int CENTER_OFS = 220,
  parameter int RING_R     = 215,
  parameter int RING_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic [3:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic [3:0] al_hour,
  input  logic [5:0] al_minute,
  input  logic [9:0] horizCounter,
  input  logic [9:0] vertCounter,
  input  logic [9:0] x_offset,
  input  logic [9:0] y_offset,
  output logic       pixel_bw
);

  localparam logic signed [22:0] C_RIN2  = 23'((RING_R - RING_W) * (RING_R - RING_W));
  localparam logic signed [22:0] C_ROUT2 = 23'(RING_R * RING_R);
  localparam logic signed [22:0] C_HUB2  = 23'sd64;

  logic       r_slow_d;
  logic [3:0] r_hour, r_al_hour;
  logic [5:0] r_min, r_sec, r_al_min;
  logic       w_rise;

  assign w_rise = slow_clk & ~r_slow_d;

  // Shadow copies keep the hands stable across a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slow_d  <= 1'b0;
      r_hour    <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_al_hour <= '0;
      r_al_min  <= '0;
    end else begin
      r_slow_d <= slow_clk;
      if (w_rise) begin
        r_hour    <= (hour      >= 4'd12) ? 4'd0 : hour;
        r_min     <= (minute    >= 6'd60) ? 6'd0 : minute;
        r_sec     <= (second    >= 6'd60) ? 6'd0 : second;
        r_al_hour <= (al_hour   >= 4'd12) ? 4'd0 : al_hour;
        r_al_min  <= (al_minute >= 6'd60) ? 6'd0 : al_minute;
      end
    end
  end

  logic [9:0] w_cx, w_cy;
  dist_t      w_dx, w_dy;

  assign w_cx = x_offset + 10'(CENTER_OFS);
  assign w_cy = y_offset + 10'(CENTER_OFS);
  assign w_dx = signed'({1'b0, horizCounter} - {1'b0, w_cx});
  assign w_dy = signed'({1'b0, vertCounter}  - {1'b0, w_cy});

  logic       r_vld;
  dist_t      r_dx, r_dy;
  logic [5:0] r_idx_sec, r_idx_min, r_idx_hr, r_idx_al;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld     <= 1'b0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_idx_sec <= '0;
      r_idx_min <= '0;
      r_idx_hr  <= '0;
      r_idx_al  <= '0;
    end else begin
      r_vld     <= 1'b1;
      r_dx      <= w_dx;
      r_dy      <= w_dy;
      r_idx_sec <= r_sec;
      r_idx_min <= r_min;
      r_idx_hr  <= hand_idx(r_hour, r_min);
      r_idx_al  <= hand_idx(r_al_hour, r_al_min);
    end
  end

  logic signed [22:0] w_dxe, w_dye, w_r2;
  logic               w_ring, w_hub, w_tick;
  logic               w_sec, w_min, w_hr, w_al;

  assign w_dxe  = 23'(r_dx);
  assign w_dye  = 23'(r_dy);
  assign w_r2   = w_dxe * w_dxe + w_dye * w_dye;
  assign w_ring = (w_r2 >= C_RIN2) && (w_r2 <= C_ROUT2);
  assign w_hub  = (w_r2 <= C_HUB2);

  always_comb begin
    w_tick = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (near3(r_dx, TICK_X[i]) && near3(r_dy, TICK_Y[i])) w_tick = 1'b1;
    end
  end

  hand_hit u_sec (.i_dx(r_dx), .i_dy(r_dy), .i_idx(r_idx_sec), .i_len(SEC_L), .i_wid(SEC_W), .o_hit(w_sec));
  hand_hit u_min (.i_dx(r_dx), .i_dy(r_dy), .i_idx(r_idx_min), .i_len(MIN_L), .i_wid(MIN_W), .o_hit(w_min));
  hand_hit u_hr  (.i_dx(r_dx), .i_dy(r_dy), .i_idx(r_idx_hr),  .i_len(HR_L),  .i_wid(HR_W),  .o_hit(w_hr));
  hand_hit u_al  (.i_dx(r_dx), .i_dy(r_dy), .i_idx(r_idx_al),  .i_len(AL_L),  .i_wid(AL_W),  .o_hit(w_al));

  always_ff @(posedge clk) begin
    if (reset) pixel_bw <= 1'b0;
    else       pixel_bw <= r_vld & (w_ring | w_hub | w_tick | w_sec | w_min | w_hr | w_al);
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_renderer.sv
// Directed self-checking bench for clock_renderer with hand-computed pixel expectations.
`default_nettype none

module tb_clock_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk = 1'b0;
  logic [3:0] hour = 4'd3;
  logic [5:0] minute = 6'd0;
  logic [5:0] second = 6'd0;
  logic [3:0] al_hour = 4'd0;
  logic [5:0] al_minute = 6'd0;
  logic [9:0] horizCounter = 10'd0;
  logic [9:0] vertCounter = 10'd0;
  logic [9:0] x_offset = 10'd25;
  logic [9:0] y_offset = 10'd15;
  logic       pixel_bw;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_renderer dut (
    .clk(clk), .reset(reset), .slow_clk(slow_clk),
    .hour(hour), .minute(minute), .second(second),
    .al_hour(al_hour), .al_minute(al_minute),
    .horizCounter(horizCounter), .vertCounter(vertCounter),
    .x_offset(x_offset), .y_offset(y_offset),
    .pixel_bw(pixel_bw)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_px(input string tag, input int x, input int y, input logic exp);
    @(negedge clk);
    horizCounter = 10'(x);
    vertCounter  = 10'(y);
    repeat (2) @(posedge clk);
    #1;
    chk(tag, {31'b0, pixel_bw}, {31'b0, exp});
  endtask

  task automatic latch(input int h, input int m, input int s, input int ah, input int am);
    @(negedge clk);
    hour = 4'(h); minute = 6'(m); second = 6'(s);
    al_hour = 4'(ah); al_minute = 6'(am);
    slow_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    slow_clk = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Output must stay low while reset is held, even on lit pixels.
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      horizCounter = 10'(245 + 60 * i);
      vertCounter  = 10'(235 - 50 * i);
      @(posedge clk);
      #1;
      chk("reset_hold", {31'b0, pixel_bw}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Shadows are zero: hands point up although inputs say 3:00.
    check_px("post_reset_up", 245, 85, 1'b1);
    check_px("post_reset_no_hr", 345, 235, 1'b0);

    latch(0, 0, 0, 0, 0);
    check_px("hub", 245, 235, 1'b1);
    check_px("hands_up", 245, 85, 1'b1);
    check_px("blank_diag", 295, 285, 1'b0);

    latch(3, 0, 0, 0, 0);
    check_px("hour_3", 345, 235, 1'b1);
    check_px("hour_tip", 365, 235, 1'b1);
    check_px("hour_past_tip", 366, 235, 1'b0);
    check_px("minute_up", 245, 75, 1'b1);
    check_px("below_blank", 245, 400, 1'b0);
    check_px("ring", 458, 235, 1'b1);
    check_px("outside_ring", 463, 235, 1'b0);
    check_px("tick_12", 245, 40, 1'b1);

    // Latency: exactly two cycles from beam position to output.
    check_px("lat_pre", 463, 235, 1'b0);
    @(negedge clk);
    horizCounter = 10'd458;
    @(posedge clk); #1;
    chk("lat_1cyc", {31'b0, pixel_bw}, 32'd0);
    @(posedge clk); #1;
    chk("lat_2cyc", {31'b0, pixel_bw}, 32'd1);

    check_px("min30_before", 245, 385, 1'b0);
    @(negedge clk);
    minute = 6'd30;
    repeat (4) @(negedge clk);
    check_px("min30_no_edge", 245, 385, 1'b0);
    latch(3, 30, 0, 0, 0);
    check_px("min30_after", 245, 385, 1'b1);

    latch(3, 60, 15, 0, 0);
    check_px("min60_up", 245, 75, 1'b1);
    check_px("min60_not_down", 245, 385, 1'b0);

    latch(13, 0, 0, 6, 0);
    check_px("hr13_zero", 345, 235, 1'b0);
    check_px("alarm_down", 245, 305, 1'b1);
    check_px("alarm_edge_w", 246, 305, 1'b1);
    check_px("alarm_past_w", 247, 305, 1'b0);
    check_px("alarm_past_len", 245, 328, 1'b0);

    // Mid-line reset and recovery.
    check_px("pre_reset_hub", 245, 235, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset", {31'b0, pixel_bw}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("release_1", {31'b0, pixel_bw}, 32'd0);
    @(posedge clk); #1;
    chk("release_2", {31'b0, pixel_bw}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
